instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//   Program sequencer between the instruction ROM and the datapath (register file + ALU).
//   Drives the ROM address from a program counter and latches each 26-bit word.
//   Splits the word into register, control and immediate fields.
//   Issues one instruction at a time over a valid/ready handshake, then stops at end of program.
// PARAMETERS
//   ADDR_W    6    ROM address / PC width
//   INSTR_W   26   instruction word width; field map below is fixed for 26
//   PROG_LEN  6    number of valid program words; legal range 1..2**ADDR_W
// PORTS
//   clk          in   1        rising-edge clock
//   rst          in   1        asynchronous, active-high reset
//   start        in   1        level, sampled each clk; launches the program from address 0
//   rom_addr     out  ADDR_W   address to the combinational ROM (= PC)
//   rom_data     in   INSTR_W  ROM word for rom_addr, valid in the same cycle
//   issue_valid  out  1        decoded instruction present on outputs
//   issue_ready  in   1        datapath accepts the instruction this cycle
//   src_a        out  4        IR[25:22] first source register
//   src_b        out  4        IR[21:18] second source register
//   dst          out  4        IR[17:14] destination register
//   reg_we       out  1        IR[13] & issue_valid (register write enable)
//   imm_sel      out  1        IR[12]: 1 = B operand is imm, 0 = src_b
//   aux          out  1        IR[11], passed through unmodified
//   alu_op       out  3        IR[10:8] ALU operation
//   imm          out  8        IR[7:0] immediate
//   busy         out  1        state is FETCH or ISSUE
//   done         out  1        state is DONE
// BEHAVIOUR
//   Reset (async): state=IDLE, PC=0, IR=0; all outputs 0, rom_addr=0.
//   IDLE:  on start=1 -> FETCH with PC=0.
//   FETCH: rom_addr=PC; IR<=rom_data at clock edge; -> ISSUE.
//   ISSUE: issue_valid=1; field outputs come from IR and are stable while valid.
//     If issue_ready=0: hold state, IR and outputs unchanged (stall).
//     If issue_ready=1 (transfer) and PC==PROG_LEN-1: -> DONE, PC unchanged.
//     If issue_ready=1 and PC<PROG_LEN-1: PC<=PC+1, -> FETCH.
//   DONE: done=1, held until start=1, which sets PC=0 and goes to FETCH (program restart).
//   start is ignored in FETCH and ISSUE.
//   Timing: 2 cycles per instruction minimum; PROG_LEN=6 with ready tied high = 12 cycles start->done.
//   issue_valid and reg_we are 0 outside ISSUE.
//     src_a, src_b, dst, imm_sel, aux, alu_op, imm keep the last IR value (no spurious writes).
//   PC never wraps: PROG_LEN=2**ADDR_W stops at address 2**ADDR_W-1 and enters DONE.
//   Reset mid-program: immediate return to IDLE, PC=0.
//     An in-flight instruction is dropped (issue_valid falls asynchronously).
//   PC and IR update only on rising clk edges outside reset.
//   No combinational path from issue_ready to issue_valid.
// TESTING
//   1 Reset then idle: rst=1 then 0, start=0 for 5 cycles -> issue_valid=0, busy=0, done=0, rom_addr=0.
//   2 Word 0 issue: start pulse, ready=1.
//     First issue -> dst=0, reg_we=1, imm_sel=1, alu_op=000, imm=8'h7D.
//   3 Word 3 issue: fourth issue -> src_a=0, src_b=1, dst=10, reg_we=1, imm_sel=0, alu_op=110, imm=0.
//   4 Word 5 and end of program: sixth issue -> src_a=10, src_b=11, dst=12, alu_op=000.
//     done=1 one cycle later; exactly 6 issues; 12 cycles from start sample.
//   5 Stall: ready=0 for 3 cycles during issue 2.
//     Outputs frozen (imm=8'h1E, dst=1); rom_addr stays 1; issue counted once.
//   6 Reset and restart:
//     rst pulse during issue 4 -> IDLE, PC=0, no further issues.
//     start while in DONE -> sequence replays from word 0.

Source files
------------

// File: rtl/instr_sequencer.sv
// Program sequencer: walks the instruction ROM from address 0 and latches
// each word into the instruction register. It then presents the decoded
// fields to the datapath over a valid/ready handshake, one instruction at a
// time, and parks in DONE after the last program word has been accepted.
module instr_sequencer #(
    parameter int ADDR_W   = 6,
    parameter int INSTR_W  = 26,
    parameter int PROG_LEN = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [3:0]        src_a,
    output logic [3:0]        src_b,
    output logic [3:0]        dst,
    output logic              reg_we,
    output logic              imm_sel,
    output logic              aux,
    output logic [2:0]        alu_op,
    output logic [7:0]        imm,
    output logic              busy,
    output logic              done
);

    // Address of the final program word; reaching it ends the program
    // instead of incrementing, so the PC can never wrap.
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   pc_reg, pc_next;
    logic [INSTR_W-1:0]  ir_reg;
    logic                ir_load;

    // State, program counter and instruction register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
            ir_reg    <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            if (ir_load) begin
                ir_reg <= rom_data;
            end
        end
    end

    // Next-state logic: fetch, issue until accepted, advance or finish.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_load    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    pc_next    = '0;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                ir_load    = 1'b1;
                state_next = ISSUE;
            end
            ISSUE: begin
                if (issue_ready) begin
                    if (pc_reg == LAST_PC) begin
                        state_next = DONE;
                    end else begin
                        pc_next    = pc_reg + 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    pc_next    = '0;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // issue_valid depends only on registered state, so there is no
    // combinational path from issue_ready back to issue_valid.
    assign issue_valid = (state_reg == ISSUE);
    assign busy        = (state_reg == FETCH) || (state_reg == ISSUE);
    assign done        = (state_reg == DONE);
    assign rom_addr    = pc_reg;

    // Field outputs hold the last IR value; only the write enable is gated
    // so the register file never sees a spurious write outside ISSUE.
    assign src_a   = ir_reg[25:22];
    assign src_b   = ir_reg[21:18];
    assign dst     = ir_reg[17:14];
    assign reg_we  = ir_reg[13] & issue_valid;
    assign imm_sel = ir_reg[12];
    assign aux     = ir_reg[11];
    assign alu_op  = ir_reg[10:8];
    assign imm     = ir_reg[7:0];

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: directed program runs with a scoreboard.
// The stimulus side pushes the expected instruction fields when a run
// starts. A negedge monitor compares every valid cycle against the queue
// head and pops the head on each accepted transfer.
module tb_instr_sequencer;

    localparam int ADDR_W   = 6;
    localparam int INSTR_W  = 26;
    localparam int PROG_LEN = 6;

    logic               clk;
    logic               rst;
    logic               start;
    logic [ADDR_W-1:0]  rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic               issue_valid;
    logic               issue_ready;
    logic [3:0]         src_a, src_b, dst;
    logic               reg_we, imm_sel, aux;
    logic [2:0]         alu_op;
    logic [7:0]         imm;
    logic               busy, done;

    instr_sequencer #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .PROG_LEN(PROG_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .src_a      (src_a),
        .src_b      (src_b),
        .dst        (dst),
        .reg_we     (reg_we),
        .imm_sel    (imm_sel),
        .aux        (aux),
        .alu_op     (alu_op),
        .imm        (imm),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Program ROM, combinational. Fields in order:
    // src_a, src_b, dst, we, imm_sel, aux, alu_op, imm.
    always_comb begin
        case (rom_addr)
            6'd0:    rom_data = {4'd0,  4'd0,  4'd0,  1'b1, 1'b1, 1'b0, 3'd0, 8'h7D};
            6'd1:    rom_data = {4'd2,  4'd0,  4'd1,  1'b1, 1'b1, 1'b0, 3'd1, 8'h1E};
            6'd2:    rom_data = {4'd1,  4'd0,  4'd5,  1'b0, 1'b0, 1'b1, 3'd2, 8'hA5};
            6'd3:    rom_data = {4'd0,  4'd1,  4'd10, 1'b1, 1'b0, 1'b0, 3'd6, 8'h00};
            6'd4:    rom_data = {4'd15, 4'd3,  4'd7,  1'b1, 1'b1, 1'b1, 3'd5, 8'hFF};
            6'd5:    rom_data = {4'd10, 4'd11, 4'd12, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00};
            default: rom_data = '0;
        endcase
    end

    typedef struct {
        int addr;
        int src_a;
        int src_b;
        int dst;
        int we;
        int imm_sel;
        int aux;
        int alu_op;
        int imm;
    } exp_t;

    exp_t exp_tab [PROG_LEN];
    exp_t sb_q [$];

    int checks   = 0;
    int failures = 0;
    int n_issued = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Monitor: compare every valid cycle with the queue head and pop the
    // head on each accepted transfer.
    always @(negedge clk) begin
        if (!rst && issue_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_issue: got issue at rom_addr=%0d expected none", rom_addr);
            end else begin
                exp_t e;
                e = sb_q[0];
                check("rom_addr", int'(rom_addr), e.addr);
                check("src_a",    int'(src_a),    e.src_a);
                check("src_b",    int'(src_b),    e.src_b);
                check("dst",      int'(dst),      e.dst);
                check("reg_we",   int'(reg_we),   e.we);
                check("imm_sel",  int'(imm_sel),  e.imm_sel);
                check("aux",      int'(aux),      e.aux);
                check("alu_op",   int'(alu_op),   e.alu_op);
                check("imm",      int'(imm),      e.imm);
                if (issue_ready) begin
                    void'(sb_q.pop_front());
                    n_issued++;
                    $display("issue addr=%0d src_a=%0d src_b=%0d dst=%0d we=%0d isel=%0d aux=%0d op=%0d imm=%02h",
                             rom_addr, src_a, src_b, dst, reg_we, imm_sel, aux, alu_op, imm);
                end
            end
        end
    end

    // One program run. Pushes the first n_expect words as expected issues,
    // stalls stall_n cycles on stall_addr, and asserts reset while the
    // instruction at abort_addr is being issued (-1 disables either).
    task automatic run(input int n_expect, input int stall_addr, input int stall_n,
                       input int abort_addr, output int cycles);
        int stalls;
        for (int i = 0; i < n_expect; i++) sb_q.push_back(exp_tab[i]);
        issue_ready = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cycles = 0;
        stalls = 0;
        while (!done && cycles < 200) begin
            if (issue_valid && int'(rom_addr) == abort_addr) begin
                issue_ready = 1'b0;
                rst = 1'b1;
                #2;
                check("abort_issue_valid_async", int'(issue_valid), 0);
                check("abort_rom_addr", int'(rom_addr), 0);
                check("abort_busy", int'(busy), 0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
            issue_ready = !(issue_valid && int'(rom_addr) == stall_addr && stalls < stall_n);
            if (!issue_ready) stalls++;
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL run_timeout: got done=0 after %0d cycles expected done=1", cycles);
        end
    endtask

    initial begin
        int cycles;
        int base;

        exp_tab[0] = '{0, 0,  0,  0,  1, 1, 0, 0, 8'h7D};
        exp_tab[1] = '{1, 2,  0,  1,  1, 1, 0, 1, 8'h1E};
        exp_tab[2] = '{2, 1,  0,  5,  0, 0, 1, 2, 8'hA5};
        exp_tab[3] = '{3, 0,  1,  10, 1, 0, 0, 6, 8'h00};
        exp_tab[4] = '{4, 15, 3,  7,  1, 1, 1, 5, 8'hFF};
        exp_tab[5] = '{5, 10, 11, 12, 1, 0, 0, 0, 8'h00};

        // Reset then idle.
        rst = 1'b1;
        start = 1'b0;
        issue_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("idle_issue_valid", int'(issue_valid), 0);
        check("idle_busy",        int'(busy),        0);
        check("idle_done",        int'(done),        0);
        check("idle_rom_addr",    int'(rom_addr),    0);
        check("idle_reg_we",      int'(reg_we),      0);
        check("idle_imm",         int'(imm),         0);

        // Full program with ready tied high.
        base = n_issued;
        run(6, -1, 0, -1, cycles);
        check("run1_cycles", cycles, 12);
        check("run1_issues", n_issued - base, 6);
        @(posedge clk);
        #1;
        check("run1_done_held",   int'(done),        1);
        check("run1_valid_low",   int'(issue_valid), 0);
        check("run1_reg_we_low",  int'(reg_we),      0);
        check("run1_busy_low",    int'(busy),        0);
        check("run1_dst_kept",    int'(dst),         12);

        // Restart from DONE with a 3-cycle stall on the second instruction.
        base = n_issued;
        run(6, 1, 3, -1, cycles);
        check("run2_cycles", cycles, 15);
        check("run2_issues", n_issued - base, 6);

        // Reset while the fourth instruction is being issued.
        base = n_issued;
        run(3, -1, 0, 3, cycles);
        repeat (4) @(posedge clk);
        #1;
        check("abort_issues",     n_issued - base,   3);
        check("abort_queue",      sb_q.size(),       0);
        check("abort_idle_valid", int'(issue_valid), 0);
        check("abort_idle_done",  int'(done),        0);
        check("abort_idle_dst",   int'(dst),         0);

        // Start from IDLE again after the reset.
        base = n_issued;
        run(6, -1, 0, -1, cycles);
        check("run4_cycles", cycles, 12);
        check("run4_issues", n_issued - base, 6);
        check("final_queue", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
